shift_add_mult: RTL and testbench

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

---
 rtl/bitadder_pkg.sv | 16 +
 rtl/add_shift_step.sv | 39 +++
 rtl/shift_add_mult.sv | 118 +++++++++++
 tb/tb_shift_add_mult.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/bitadder_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encodings
// and the default operand width.
package bitadder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // Binary-encoded FSM states; S_STEP is only reachable in the merged-step build.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADD   = 3'd1,
    S_SHIFT = 3'd2,
    S_DONE  = 3'd3,
    S_STEP  = 3'd4
  } state_t;

endpackage

// File: rtl/add_shift_step.sv
// Datapath for one multiply step: optional conditional add of M into {C,A}
// (gated by Q[0]), followed by an optional right shift of {C,A,Q}.
module add_shift_step
  import bitadder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             c_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] m_in,
  input  logic             do_add,
  input  logic             do_shift,
  output logic             c_out,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] ca;

  // Add stage feeds the shift stage so both can happen in one cycle.
  always_comb begin
    sum = {1'b0, a_in} + {1'b0, m_in};
    ca  = {c_in, a_in};
    if (do_add) begin
      ca = q_in[0] ? sum : {1'b0, a_in};
    end
    c_out = ca[WIDTH];
    a_out = ca[WIDTH-1:0];
    q_out = q_in;
    if (do_shift) begin
      c_out = 1'b0;
      a_out = ca[WIDTH:1];
      q_out = {ca[0], q_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/shift_add_mult.sv
// Unsigned sequential shift-and-add multiplier. product = {A,Q}.
// Build option SHIFT_ADD_MULT_FAST_STEP_EN merges ADD and SHIFT into a single
// STEP state (WIDTH-cycle latency instead of 2*WIDTH).
module shift_add_mult
  import bitadder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

`ifdef SHIFT_ADD_MULT_FAST_STEP_EN
  localparam state_t FIRST_ST = S_STEP;
`else
  localparam state_t FIRST_ST = S_ADD;
`endif

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic             c;
  logic [CNT_W-1:0] count;

  logic             do_add;
  logic             do_shift;
  logic             nxt_c;
  logic [WIDTH-1:0] nxt_a;
  logic [WIDTH-1:0] nxt_q;

  // Which datapath stages are active in the current state.
  assign do_add   = (state == S_ADD)   || (state == S_STEP);
  assign do_shift = (state == S_SHIFT) || (state == S_STEP);

  add_shift_step #(.WIDTH(WIDTH)) u_step (
    .c_in    (c),
    .a_in    (a),
    .q_in    (q),
    .m_in    (m),
    .do_add  (do_add),
    .do_shift(do_shift),
    .c_out   (nxt_c),
    .a_out   (nxt_a),
    .q_out   (nxt_q)
  );

  assign product = {a, q};

  // Control FSM and operand/accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a     <= '0;
      q     <= '0;
      m     <= '0;
      c     <= 1'b0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            m     <= multiplicand;
            q     <= multiplier;
            a     <= '0;
            c     <= 1'b0;
            count <= CNT_W'(WIDTH);
            busy  <= 1'b1;
            state <= FIRST_ST;
          end
        end
`ifdef SHIFT_ADD_MULT_FAST_STEP_EN
        S_STEP: begin
`else
        S_ADD: begin
          c     <= nxt_c;
          a     <= nxt_a;
          state <= S_SHIFT;
        end
        S_SHIFT: begin
`endif
          c     <= nxt_c;
          a     <= nxt_a;
          q     <= nxt_q;
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= FIRST_ST;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult.sv
// Testbench for shift_add_mult: transaction-level model plus directed vectors.
module tb_shift_add_mult;

  localparam int W = 4;
`ifdef SHIFT_ADD_MULT_FAST_STEP_EN
  localparam int LAT = W;
`else
  localparam int LAT = 2 * W;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] mcand = 4'd0;
  logic [3:0] mplier = 4'd0;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  shift_add_mult #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .multiplicand(mcand),
    .multiplier  (mplier),
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an accepted start owns the unit for LAT+1 cycles, the last of
  // which is the done cycle; the result is M*Q and is held afterwards.
  int         rem = 0;
  logic [7:0] pend = 8'd0;
  logic [7:0] last = 8'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem  = 0;
      pend = 8'd0;
      last = 8'd0;
    end else if (rem > 0) begin
      rem = rem - 1;
      if (rem == 1) last = pend;
    end else if (start) begin
      rem  = LAT + 1;
      pend = 8'(mcand) * 8'(mplier);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("busy", 16'(busy), 16'(rem > 0));
      chk("done", 16'(done), 16'(rem == 1));
      if (rem <= 1) chk("product", 16'(product), 16'(last));
    end
  end

  // One multiply with hand-computed result; optionally pokes start mid-run.
  task automatic do_op(input logic [3:0] m, input logic [3:0] q, input logic [7:0] exp,
                       input string nm, input bit disturb, input bit sync);
    int n;
    bit got;
    if (sync) begin
      @(posedge clk);
      #1;
    end
    mcand  = m;
    mplier = q;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    mcand  = ~m;
    mplier = ~q;
    n   = 0;
    got = 1'b0;
    for (int i = 0; i < 3 * LAT; i++) begin
      @(negedge clk);
      n++;
      if (done) begin
        got = 1'b1;
        break;
      end
      if (disturb && n == 2) begin
        start  = 1'b1;
        mcand  = 4'd2;
        mplier = 4'd3;
      end
      if (disturb && n == 3) start = 1'b0;
    end
    chk({nm, " done seen"}, 16'(got), 16'd1);
    chk({nm, " latency"}, 16'(n), 16'(LAT + 1));
    chk({nm, " product"}, 16'(product), 16'(exp));
    repeat (2) @(negedge clk);
    chk({nm, " hold"}, 16'(product), 16'(exp));
  endtask

  initial begin
    int ndone;
    @(posedge clk);
    #1;
    check_en = 1'b1;
    chk("reset busy", 16'(busy), 16'd0);
    chk("reset done", 16'(done), 16'd0);
    chk("reset product", 16'(product), 16'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    do_op(4'd13, 4'd11, 8'h8F, "13x11", 1'b0, 1'b1);
    do_op(4'd15, 4'd15, 8'hE1, "15x15", 1'b0, 1'b1);
    do_op(4'd9,  4'd0,  8'h00, "9x0",   1'b0, 1'b1);
    do_op(4'd0,  4'd9,  8'h00, "0x9",   1'b0, 1'b1);
    do_op(4'd13, 4'd11, 8'h8F, "13x11 poked", 1'b1, 1'b1);

    // Abort 15x15 partway through with an asynchronous reset.
    @(posedge clk);
    #1;
    mcand  = 4'd15;
    mplier = 4'd15;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort busy", 16'(busy), 16'd0);
    chk("abort done", 16'(done), 16'd0);
    chk("abort product", 16'(product), 16'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    do_op(4'd6, 4'd7, 8'h2A, "6x7 after reset", 1'b0, 1'b0);

    // Start held high: back-to-back operations, one per idle visit.
    @(posedge clk);
    #1;
    mcand  = 4'd5;
    mplier = 4'd3;
    start  = 1'b1;
    ndone  = 0;
    for (int i = 0; i < 2 * LAT + 4; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("b2b product", 16'(product), 16'd15);
      end
    end
    start = 1'b0;
    chk("b2b count", 16'(ndone), 16'd2);
    repeat (LAT + 4) @(negedge clk);
    chk("final idle busy", 16'(busy), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
